// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory with a fixed read latency.
// One transaction in flight; round-robin between ports, fetch flush suppresses fetch completions.
module mem_arbiter #(
  parameter int XLEN = 32,
  parameter int LAT  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  input  logic            i_kill,
  output logic            i_gnt,
  output logic            i_done,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_done,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic {IDLE, WAIT} stateT;

  localparam logic [1:0] CntInit = 2'(LAT - 1);

  stateT           state;
  logic [1:0]      cnt;
  logic            lastData;  // last-granted port, which is also the owner of the outstanding transaction
  logic            killed;
  logic [XLEN-1:0] iHeld;
  logic [XLEN-1:0] dHeld;

  logic completing;
  logic issueSlot;
  logic grantI;
  logic grantD;
  logic iFinish;
  logic dFinish;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    completing = (state == WAIT) && (cnt == 2'd0);
    issueSlot  = (state == IDLE) || completing;
    grantI     = 1'b0;
    grantD     = 1'b0;
    // A flushed fetch never competes, so data wins outright when both are asserted.
    if (reset && issueSlot) begin
      if (i_req && !i_kill && d_req) begin
        grantD = !lastData;
        grantI = lastData;
      end else begin
        grantI = i_req && !i_kill;
        grantD = d_req;
      end
    end
  end

  assign iFinish = completing && !lastData && !killed && !i_kill;
  assign dFinish = completing && lastData;

  assign i_gnt     = grantI;
  assign d_gnt     = grantD;
  assign mem_req   = grantI || grantD;
  assign mem_we    = grantD && d_we;
  assign mem_addr  = grantD ? d_addr : (grantI ? i_addr : '0);
  assign mem_wdata = grantD ? d_wdata : '0;

  assign i_done  = iFinish;
  assign d_done  = dFinish;
  assign i_rdata = iFinish ? mem_rdata : iHeld;
  assign d_rdata = dFinish ? mem_rdata : dHeld;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      lastData <= 1'b0;
      killed   <= 1'b0;
      iHeld    <= '0;
      dHeld    <= '0;
    end else begin
      if (iFinish) iHeld <= mem_rdata;
      if (dFinish) dHeld <= mem_rdata;
      if (mem_req) begin
        state    <= WAIT;
        cnt      <= CntInit;
        lastData <= grantD;
        killed   <= 1'b0;
      end else begin
        if (state == WAIT) begin
          if (cnt == 2'd0) state <= IDLE;
          else             cnt   <= cnt - 2'd1;
        end
        // The memory cycle still runs to completion; only the fetch done pulse is dropped.
        if (i_kill && state == WAIT && !lastData) killed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a cycle-count reference model predicts grants,
// bus contents and completions; a separate monitor pops expected completions and compares.
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam int LAT  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            i_req = 1'b0, i_kill = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [XLEN-1:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic            i_gnt, i_done, d_gnt, d_done, mem_req, mem_we;
  logic [XLEN-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  mem_arbiter #(.XLEN(XLEN), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
    .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isData;
    bit          isWrite;
    bit          killed;
    int          due;
    logic [31:0] data;
  } txnT;

  txnT             sb[$];
  logic [31:0]     memArr[logic [31:0]];
  logic [31:0]     sched[int];
  int              cyc = 0;
  int              busyUntil = 0;
  bit              lastData = 1'b0;
  bit              iGot = 1'b0, dGot = 1'b0;
  logic [31:0]     lastI = '0, lastD = '0;
  bit              lastIValid = 1'b1, lastDValid = 1'b1;
  int              checks = 0;
  int              failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  // Reference model: a port may issue once the previous transaction's completion cycle is reached.
  always @(negedge clk) begin
    bit          expI, expD, iw, dw;
    logic [31:0] expAddr;
    if (!reset) begin
      sb.delete();
      busyUntil = 0;
      lastData  = 1'b0;
      iGot      = 1'b0;
      dGot      = 1'b0;
      check("reset ctrl", {26'd0, i_gnt, i_done, d_gnt, d_done, mem_req, mem_we}, 32'd0);
      check("reset data", mem_addr | mem_wdata | i_rdata | d_rdata, 32'd0);
    end else begin
      expI = 1'b0;
      expD = 1'b0;
      if (cyc >= busyUntil) begin
        iw = i_req && !i_kill;
        dw = d_req;
        if (iw && dw) begin
          expD = !lastData;
          expI = lastData;
        end else begin
          expI = iw;
          expD = dw;
        end
      end
      expAddr = expD ? d_addr : (expI ? i_addr : 32'd0);
      check("i_gnt", {31'd0, i_gnt}, {31'd0, expI});
      check("d_gnt", {31'd0, d_gnt}, {31'd0, expD});
      check("mem_req", {31'd0, mem_req}, {31'd0, expI | expD});
      check("mem_addr", mem_addr, expAddr);
      check("mem_we", {31'd0, mem_we}, {31'd0, expD & d_we});
      check("mem_wdata", mem_wdata, expD ? d_wdata : 32'd0);
      if (i_kill) begin
        for (int k = 0; k < sb.size(); k++) begin
          txnT t;
          t = sb[k];
          if (!t.isData && t.due > cyc) begin
            t.killed = 1'b1;
            sb[k] = t;
          end
        end
      end
      if (expI || expD) begin
        txnT t;
        t.isData  = expD;
        t.isWrite = expD && d_we;
        t.killed  = 1'b0;
        t.due     = cyc + LAT;
        t.data    = memRead(expAddr);
        sb.push_back(t);
        busyUntil = cyc + LAT;
        lastData  = expD;
      end
      // Physical memory: responds to whatever the DUT actually puts on the bus.
      if (mem_req && mem_we) memArr[mem_addr] = mem_wdata;
      else if (mem_req)      sched[cyc + LAT] = memRead(mem_addr);
      iGot = i_gnt;
      dGot = d_gnt;
    end
  end

  // Monitor: compares done pulses and read data against the expected-completion queue.
  always @(negedge clk) begin
    txnT e;
    bit  have, eI, eD;
    if (!reset) begin
      lastI      = '0;
      lastD      = '0;
      lastIValid = 1'b1;
      lastDValid = 1'b1;
    end else begin
      have = 1'b0;
      eI   = 1'b0;
      eD   = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e    = sb.pop_front();
        have = 1'b1;
        if (e.isData) eD = 1'b1;
        else          eI = !e.killed && !i_kill;
      end
      check("i_done", {31'd0, i_done}, {31'd0, eI});
      check("d_done", {31'd0, d_done}, {31'd0, eD});
      if (eI) begin
        check("i_rdata", i_rdata, e.data);
        lastI      = e.data;
        lastIValid = 1'b1;
      end else if (have && !e.isData) begin
        lastIValid = 1'b0;
      end else if (lastIValid) begin
        check("i_rdata hold", i_rdata, lastI);
      end
      if (eD) begin
        if (!e.isWrite) begin
          check("d_rdata", d_rdata, e.data);
          lastD      = e.data;
          lastDValid = 1'b1;
        end else begin
          lastDValid = 1'b0;
        end
      end else if (lastDValid) begin
        check("d_rdata hold", d_rdata, lastD);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sched.exists(cyc)) begin
      mem_rdata = sched[cyc];
      sched.delete(cyc);
    end else begin
      mem_rdata = $urandom;
    end
  endtask

  task automatic run(input int n, input bit rnd, input bit drop);
    repeat (n) begin
      step();
      if (drop && iGot) i_req = 1'b0;
      if (drop && dGot) d_req = 1'b0;
      if (rnd) begin
        if (!i_req && $urandom_range(0, 3) != 0) begin
          i_req  = 1'b1;
          i_addr = 32'($urandom_range(0, 15)) << 2;
        end
        if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req   = 1'b1;
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = 32'($urandom_range(0, 15)) << 2;
          d_wdata = $urandom;
        end
        i_kill = ($urandom_range(0, 5) == 0);
      end
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    doReset();
    // Fetch only.
    i_req = 1'b1; i_addr = 32'h10;
    run(5, 0, 1);
    // Tie after reset, both held: data, fetch, data.
    doReset();
    i_req = 1'b1; i_addr = 32'h14; d_req = 1'b1; d_addr = 32'h18;
    run(6, 0, 0);
    i_req = 1'b0; d_req = 1'b0;
    run(3, 0, 1);
    // Kill of an outstanding fetch.
    i_req = 1'b1; i_addr = 32'h20;
    step();
    i_req = 1'b0; i_kill = 1'b1;
    step();
    i_kill = 1'b0;
    run(3, 0, 1);
    // Kill landing in the fetch completion cycle.
    i_req = 1'b1; i_addr = 32'h24;
    step();
    i_req = 1'b0;
    step();
    i_kill = 1'b1;
    step();
    i_kill = 1'b0;
    run(3, 0, 1);
    // Write then read back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    run(4, 0, 1);
    d_req = 1'b1; d_we = 1'b0;
    run(4, 0, 1);
    // Reset in the middle of an outstanding read, with both ports requesting.
    d_req = 1'b1; d_addr = 32'h44;
    step();
    reset = 1'b0; i_req = 1'b1; i_addr = 32'h48; d_req = 1'b1;
    #1;
    check("reset at once ctrl", {26'd0, i_gnt, i_done, d_gnt, d_done, mem_req, mem_we}, 32'd0);
    check("reset at once data", mem_addr | mem_wdata | i_rdata | d_rdata, 32'd0);
    step();
    step();
    reset = 1'b1;
    run(6, 0, 1);
    // Kill plus data with the pointer favouring fetch.
    d_req = 1'b1; d_addr = 32'h8;
    run(3, 0, 1);
    i_req = 1'b1; i_addr = 32'h30; d_req = 1'b1; d_addr = 32'hC; i_kill = 1'b1;
    step();
    i_kill = 1'b0;
    if (dGot) d_req = 1'b0;
    run(5, 0, 1);
    // Randomized traffic with occasional resets.
    repeat (6) begin
      run(500, 1, 1);
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
    end
    run(300, 1, 1);
    i_req = 1'b0; d_req = 1'b0; i_kill = 1'b0;
    run(LAT + 3, 0, 1);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
